seg7_scan_decoder: RTL

- Receiving end of the board's multiplexed seven-segment display interface. It samples the scanned o_seg/o_sel lines that board_top produces and rebuilds the 32-bit hex value being displayed.
- Used in simulation benches and on-board self-check to compare the displayed value against CPU register contents, without hierarchical peeking.
- Emits one result per complete 8-digit scan frame, with a glyph-error flag.

---
 rtl/seg7_scan_decoder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Rebuilds the 32-bit hex value shown on a scanned 8-digit seven-segment display
// by sampling segment/select lines, settling each digit and assembling full frames.
module seg7_scan_decoder #(
  parameter int SETTLE         = 4,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [7:0]  i_seg,
  input  logic [7:0]  i_sel,
  output logic [31:0] o_value,
  output logic        o_valid,
  output logic        o_glyph_err,
  output logic [7:0]  o_mask,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    ST_WAIT     = 2'd0,
    ST_SETTLING = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_W = 8'(SETTLE);

  logic [7:0]  seg_r, sel_r, prev_seg, prev_sel;
  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [7:0]  mask, mask_set;
  logic [31:0] shadow, shadow_new, value_r;
  logic        err_acc, glyph_err_r, valid_r;

  logic [7:0]  sel_norm;
  logic        sel_ok, stable, go_start, capture, frame_done;
  logic [2:0]  digit_idx;
  logic [3:0]  glyph_nib;
  logic        glyph_bad;

  // Select normalisation: a digit is only trusted when exactly one select is active.
  always_comb begin
    sel_norm = SEL_ACTIVE_LOW ? ~sel_r : sel_r;
    sel_ok   = (sel_norm != 8'd0) && ((sel_norm & (sel_norm - 8'd1)) == 8'd0);
    stable   = (sel_r == prev_sel) && (seg_r == prev_seg);
    digit_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel_norm[i]) digit_idx = 3'(i);
    end
  end

  // Active-low glyph table; the decimal point does not take part in decoding.
  always_comb begin
    glyph_nib = 4'h0;
    glyph_bad = 1'b0;
    case (seg_r[6:0])
      7'h40: glyph_nib = 4'h0;
      7'h79: glyph_nib = 4'h1;
      7'h24: glyph_nib = 4'h2;
      7'h30: glyph_nib = 4'h3;
      7'h19: glyph_nib = 4'h4;
      7'h12: glyph_nib = 4'h5;
      7'h02: glyph_nib = 4'h6;
      7'h78: glyph_nib = 4'h7;
      7'h00: glyph_nib = 4'h8;
      7'h10: glyph_nib = 4'h9;
      7'h08: glyph_nib = 4'hA;
      7'h03: glyph_nib = 4'hB;
      7'h46: glyph_nib = 4'hC;
      7'h21: glyph_nib = 4'hD;
      7'h06: glyph_nib = 4'hE;
      7'h0E: glyph_nib = 4'hF;
      default: glyph_bad = 1'b1;
    endcase
  end

  // Next-state logic. A changed but valid sample always restarts the count at 1.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    go_start = 1'b0;
    case (state)
      ST_WAIT: begin
        if (sel_ok) go_start = 1'b1;
        else        cnt_nx = 8'd0;
      end
      ST_SETTLING: begin
        if (!stable) begin
          if (sel_ok) go_start = 1'b1;
          else begin
            state_nx = ST_WAIT;
            cnt_nx   = 8'd0;
          end
        end else begin
          cnt_nx = (cnt < SETTLE_W) ? cnt + 8'd1 : cnt;
          if (cnt_nx == SETTLE_W) begin
            capture  = 1'b1;
            state_nx = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        if (!stable) begin
          if (sel_ok) go_start = 1'b1;
          else begin
            state_nx = ST_WAIT;
            cnt_nx   = 8'd0;
          end
        end
      end
      default: begin
        state_nx = ST_WAIT;
        cnt_nx   = 8'd0;
      end
    endcase
    if (go_start) begin
      cnt_nx = 8'd1;
      if (SETTLE_W == 8'd1) begin
        capture  = 1'b1;
        state_nx = ST_HELD;
      end else begin
        state_nx = ST_SETTLING;
      end
    end
  end

  always_comb begin
    mask_set   = mask | (8'h01 << digit_idx);
    frame_done = capture && (mask_set == 8'hFF);
    shadow_new = shadow;
    shadow_new[{digit_idx, 2'b00} +: 4] = glyph_nib;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r       <= 8'd0;
      sel_r       <= 8'd0;
      prev_seg    <= 8'd0;
      prev_sel    <= 8'd0;
      state       <= ST_WAIT;
      cnt         <= 8'd0;
      mask        <= 8'd0;
      shadow      <= 32'd0;
      err_acc     <= 1'b0;
      value_r     <= 32'd0;
      glyph_err_r <= 1'b0;
      valid_r     <= 1'b0;
    end else begin
      seg_r <= i_seg;
      sel_r <= i_sel;
      if (ena) begin
        prev_seg <= seg_r;
        prev_sel <= sel_r;
        state    <= state_nx;
        cnt      <= cnt_nx;
        // Held while ena is low so a completed frame still pulses once ena returns.
        valid_r  <= frame_done;
        if (capture) begin
          shadow <= shadow_new;
          if (frame_done) begin
            mask        <= 8'd0;
            err_acc     <= 1'b0;
            value_r     <= shadow_new;
            glyph_err_r <= err_acc | glyph_bad;
          end else begin
            mask    <= mask_set;
            err_acc <= err_acc | glyph_bad;
          end
        end
      end
    end
  end

  always_comb begin
    o_value     = value_r;
    o_valid     = valid_r & ena;
    o_glyph_err = glyph_err_r;
    o_mask      = mask;
    o_state     = state;
  end

endmodule
